dense_weight_streamer: RTL and testbench
========================================

# dense_weight_streamer

Read-side sequencer for the dense-layer weight ROM (sync read, `en`/`addr` in, `rdata` one cycle later). On a start pulse it walks the ROM from address 0 to NUM_WEIGHTS-1 in neuron-major order. It captures each returned weight into a small FIFO and presents the weights on a valid/ready stream to the dense MAC array, with neuron and frame boundary flags. Full throughput (one weight per cycle) is sustained while the consumer is ready; back-pressure never drops or duplicates a weight.

## Interface
- NUM_WEIGHTS, 507, total weights in ROM
- NUM_INPUTS, 169, weights per neuron (NUM_WEIGHTS = NUM_INPUTS × NUM_NEURONS)
- NUM_NEURONS, 3, output neurons
- ADDR_WIDTH, 10, ROM address width
- DATA_WIDTH, 8, weight width, two's complement
- FIFO_DEPTH, 4, capture FIFO entries (power of two, ≥ 3)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to stream a full weight set
- busy  out  1  streaming in progress
- done  out  1  one-cycle pulse after the final weight handshake
- mem_en  out  1  ROM read enable
- mem_addr  out  ADDR_WIDTH  ROM read address
- mem_rdata  in  DATA_WIDTH  ROM data, valid the cycle after mem_en
- w_data  out  DATA_WIDTH  weight
- w_valid  out  1  w_data valid
- w_ready  in  1  consumer accepts
- w_last_neuron  out  1  beat is the last weight of a neuron
- w_last  out  1  beat is weight NUM_WEIGHTS-1
- neuron_idx  out  2  neuron index of current beat (clog2(NUM_NEURONS))

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: start=1 → FETCH, issue counter=0, beat counter=0. start is ignored outside IDLE.
- FETCH: mem_en = (fifo_count + pending < FIFO_DEPTH). mem_addr = issue counter. Each issue increments the issue counter; issuing address NUM_WEIGHTS-1 → DRAIN.
- pending: reads issued whose data is not yet written (0..2). Data is written into the FIFO the cycle after mem_en.
- DRAIN: no reads. Each w_valid&&w_ready handshake increments the beat counter. A handshake on the beat with w_last=1 → IDLE and sets done the next cycle.
- w_last_neuron = beat counter mod NUM_INPUTS == NUM_INPUTS-1. neuron_idx = beat counter / NUM_INPUTS, kept as separate wrap counters with no divider.
- w_data/w_valid come from the FIFO head. While w_valid=1 and w_ready=0, w_data and the flags hold stable.
- busy=1 from the cycle after start is accepted until the cycle done is asserted.
- mem_en is combinational from registered state, so it goes low immediately when rst asserts.

## Timing
- Reset values: busy, done, mem_en, w_valid, w_last_neuron, w_last = 0; mem_addr, w_data, neuron_idx = 0; FIFO empty.
- Start on edge E0: mem_en=1 with addr 0 in cycle 1. Data enters the FIFO at E2. w_valid=1 in cycle 3.
- Latency start→first beat is 3 cycles. With w_ready held at 1, there is one beat per cycle and no bubbles.
- done is asserted in the cycle after the final handshake, with busy=0 in that same cycle. A start in the done cycle is accepted.
- Reset mid-operation: all state clears asynchronously. Pending ROM data is discarded. The next start restarts from address 0.
- FIFO full and write in the same cycle cannot occur, by the credit rule. Read and write in the same cycle are allowed at any fill level.

## Configuration
- DENSE_WS_CHECKSUM_EN defined:
  - adds output checksum (24 bits), the running signed sum of all handshaken weights, each sign-extended;
  - checksum clears to 0 on reset and on start acceptance, and holds its value after done.
- Not defined: the port and adder are absent. Behaviour is otherwise identical.

## Structure
- Shared package dense_pkg: state enum (IDLE/FETCH/DRAIN), width localparams derived from NUM_INPUTS/NUM_NEURONS, checksum width constant.
- Sub-module dense_ws_fifo: synchronous FIFO, parameters DEPTH/WIDTH. Each entry holds {data, last_neuron, last, neuron_idx}. Outputs count, full, empty.

## Test plan
- Reset: assert rst during a stream → all outputs read 0 within the same cycle; mem_en=0.
- ROM model with weight[i]=i mod 256, w_ready=1, start at E0:
  - w_valid first in cycle 3; 507 consecutive beats with values 0..255, 0..250;
  - w_last_neuron at beats 168, 337, 506; neuron_idx steps 0→1→2; w_last at beat 506;
  - done=1 in cycle 510.
- w_ready alternating 1/0: all 507 values arrive in order with none missing or duplicated; w_data stable while stalled; fifo_count+pending never exceeds 4.
- start pulsed at beat 50: ignored, and the stream completes normally. start in the done cycle → a second full stream begins with addr 0.
- rst asserted at beat 100, released, then start → the stream restarts at weight 0 with no stale data on w_data.
- With DENSE_WS_CHECKSUM_EN and all weights 8'hFF: checksum = −507 (24'hFFFE05) after done.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared definitions for the dense-layer weight streamer: the sequencer state type,
// the counter widths derived from the layer shape, and the checksum width.
package dense_pkg;

    localparam int unsigned DENSE_NUM_INPUTS  = 169;
    localparam int unsigned DENSE_NUM_NEURONS = 3;
    localparam int unsigned DENSE_NUM_WEIGHTS = DENSE_NUM_INPUTS * DENSE_NUM_NEURONS;

    // Position-within-neuron counter width and neuron index width
    localparam int unsigned DENSE_COL_W = $clog2(DENSE_NUM_INPUTS);
    localparam int unsigned DENSE_IDX_W = $clog2(DENSE_NUM_NEURONS);

    localparam int unsigned DENSE_CHECKSUM_W = 24;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } ws_state_e;

endpackage

// File: rtl/dense_ws_fifo.sv
// Small synchronous capture FIFO. Pointers carry one extra wrap bit so that the
// fill count falls out of a subtraction; push and pop may coincide at any level.
module dense_ws_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW:0]    wr_ptr_q;
    logic [PtrW:0]    rd_ptr_q;

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
    end

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == (PtrW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem_q[rd_ptr_q[PtrW-1:0]];

endmodule

// File: rtl/dense_weight_streamer.sv
// Read-side sequencer for the dense-layer weight ROM. Walks the ROM once per start,
// captures returned weights in a small FIFO and presents them on a valid/ready stream
// with neuron/frame boundary flags. Reads are credit-limited so the FIFO never overflows.
// Optional build macro DENSE_WS_CHECKSUM_EN adds a running signed checksum output.
module dense_weight_streamer
    import dense_pkg::*;
#(
    parameter int unsigned NUM_WEIGHTS = DENSE_NUM_WEIGHTS,
    parameter int unsigned NUM_INPUTS  = DENSE_NUM_INPUTS,
    parameter int unsigned NUM_NEURONS = DENSE_NUM_NEURONS,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_en,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    input  logic [DATA_WIDTH-1:0]       mem_rdata,
    output logic [DATA_WIDTH-1:0]       w_data,
    output logic                        w_valid,
    input  logic                        w_ready,
    output logic                        w_last_neuron,
    output logic                        w_last,
    output logic [DENSE_IDX_W-1:0]      neuron_idx
`ifdef DENSE_WS_CHECKSUM_EN
    ,
    output logic [DENSE_CHECKSUM_W-1:0] checksum
`endif
);

    localparam int unsigned EntryW = DATA_WIDTH + 2 + DENSE_IDX_W;
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;

    ws_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] issue_q, issue_d;
    logic                  done_q, done_d;
    logic                  pend_q;
    logic                  start_acc;
    logic                  handshake;

    // Capture-side position; flags are attached as each weight enters the FIFO
    logic [DENSE_COL_W-1:0] col_q;
    logic [DENSE_IDX_W-1:0] nrn_q;
    logic                   in_last_neuron;
    logic                   in_last;

    logic [EntryW-1:0]     fifo_wdata;
    logic [EntryW-1:0]     fifo_rdata;
    logic [CntW-1:0]       fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic [DATA_WIDTH-1:0]  head_data;
    logic                   head_last_neuron;
    logic                   head_last;
    logic [DENSE_IDX_W-1:0] head_idx;

    assign start_acc = (state_q == StIdle) && start;
    assign w_valid   = !fifo_empty;
    assign handshake = w_valid && w_ready;

    // Credit check counts the read still in flight so a returning weight always has room
    assign mem_en   = (state_q == StFetch) && !fifo_full &&
                      ((32'(fifo_count) + 32'(pend_q)) < FIFO_DEPTH);
    assign mem_addr = issue_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;

    assign in_last_neuron = (col_q == DENSE_COL_W'(NUM_INPUTS - 1));
    assign in_last        = in_last_neuron && (nrn_q == DENSE_IDX_W'(NUM_NEURONS - 1));
    assign fifo_wdata     = {mem_rdata, in_last_neuron, in_last, nrn_q};

    dense_ws_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EntryW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pend_q),
        .wdata (fifo_wdata),
        .pop   (handshake),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_data, head_last_neuron, head_last, head_idx} = fifo_rdata;

    // Gate the head with valid so nothing stale is ever visible on the stream
    assign w_data        = w_valid ? head_data : '0;
    assign w_last_neuron = w_valid && head_last_neuron;
    assign w_last        = w_valid && head_last;
    assign neuron_idx    = w_valid ? head_idx : '0;

    // Sequencer next-state: issue reads in FETCH, wait for the last beat in DRAIN
    always_comb begin
        state_d = state_q;
        issue_d = issue_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    issue_d = '0;
                end
            end
            StFetch: begin
                if (mem_en) begin
                    issue_d = issue_q + 1'b1;
                    if (issue_q == ADDR_WIDTH'(NUM_WEIGHTS - 1)) state_d = StDrain;
                end
            end
            StDrain: begin
                if (handshake && head_last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state, issue counter, done pulse and read-in-flight flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            issue_q <= '0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            done_q  <= done_d;
            pend_q  <= mem_en;
        end
    end

    // Capture-side wrap counters: column within neuron, then neuron index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            nrn_q <= '0;
        end else if (start_acc) begin
            col_q <= '0;
            nrn_q <= '0;
        end else if (pend_q) begin
            if (in_last_neuron) begin
                col_q <= '0;
                nrn_q <= in_last ? '0 : nrn_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

`ifdef DENSE_WS_CHECKSUM_EN
    logic [DENSE_CHECKSUM_W-1:0] sum_q;

    // Running signed sum of accepted weights; holds after done until the next start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (start_acc) begin
            sum_q <= '0;
        end else if (handshake) begin
            sum_q <= sum_q + {{(DENSE_CHECKSUM_W - DATA_WIDTH){head_data[DATA_WIDTH-1]}},
                              head_data};
        end
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_dense_weight_streamer.sv
// Self-checking bench for dense_weight_streamer: reset state, full-rate stream with an
// ignored mid-stream start, back-to-back restart from the done cycle under alternating
// back-pressure, reset mid-stream, and (with DENSE_WS_CHECKSUM_EN) the checksum.
module tb_dense_weight_streamer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       mem_en;
    logic [9:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] w_data;
    logic       w_valid;
    logic       w_ready;
    logic       w_last_neuron;
    logic       w_last;
    logic [1:0] neuron_idx;
`ifdef DENSE_WS_CHECKSUM_EN
    logic [23:0] checksum;
`endif

    int  tests_run    = 0;
    int  tests_failed = 0;
    bit  rom_ff       = 1'b0;

    always #5 clk = ~clk;

    // Synchronous ROM model: weight[i] = i mod 256, or all 8'hFF
    always_ff @(posedge clk) begin
        if (mem_en) mem_rdata <= rom_ff ? 8'hFF : mem_addr[7:0];
    end

    dense_weight_streamer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .w_data        (w_data),
        .w_valid       (w_valid),
        .w_ready       (w_ready),
        .w_last_neuron (w_last_neuron),
        .w_last        (w_last),
        .neuron_idx    (neuron_idx)
`ifdef DENSE_WS_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    task automatic test_reset();
        logic [24:0] got;
        rst = 1'b1; start = 1'b0; w_ready = 1'b0;
        @(negedge clk);
        got = {busy, done, mem_en, w_valid, w_last_neuron, w_last, mem_addr, w_data, neuron_idx};
        tests_run++;
        if (got !== 25'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %h required 0", got);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Full-rate stream; a start at beat 50 must be ignored; leaves start=1 in the done cycle
    task automatic test_full_stream();
        logic [12:0] got, exp;
        w_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if ({mem_en, mem_addr, busy, w_valid} !== {1'b1, 10'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL fs_cycle1: got en=%b addr=%0d busy=%b valid=%b required 1 0 1 0",
                     mem_en, mem_addr, busy, w_valid);
        end
        @(negedge clk);
        tests_run++;
        if (w_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fs_cycle2_valid: got %b required 0", w_valid);
        end
        for (int b = 0; b < 507; b++) begin
            @(negedge clk);
            start = (b == 50);
            got = {w_valid, w_data, w_last_neuron, w_last, neuron_idx};
            exp = {1'b1, 8'(b % 256), (b % 169) == 168, b == 506, 2'(b / 169)};
            tests_run++;
            if (got !== exp || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL fs_beat%0d: got %h busy=%b required %h busy=1", b, got, busy, exp);
            end
        end
        @(negedge clk);
        tests_run++;
        if ({done, busy, w_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL fs_done_cycle510: got done=%b busy=%b valid=%b required 1 0 0",
                     done, busy, w_valid);
        end
        start = 1'b1;
    endtask

    // Second stream started from the done cycle, consumed with w_ready alternating
    task automatic test_back_to_back();
        int          n_iss = 0;
        int          n_hs  = 0;
        int          cyc   = 0;
        bit          stalled = 1'b0;
        logic [7:0]  held = '0;
        logic [11:0] got, exp;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if ({mem_en, mem_addr, busy, done} !== {1'b1, 10'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_restart: got en=%b addr=%0d busy=%b done=%b required 1 0 1 0",
                     mem_en, mem_addr, busy, done);
        end
        while (done !== 1'b1 && cyc < 3000) begin
            w_ready = (cyc % 2 == 0);
            tests_run++;
            if (n_iss - n_hs > 4) begin
                tests_failed++;
                $display("FAIL bp_credit: got outstanding %0d required <= 4", n_iss - n_hs);
            end
            if (mem_en) begin
                tests_run++;
                if (mem_addr !== 10'(n_iss)) begin
                    tests_failed++;
                    $display("FAIL bp_addr: got %0d required %0d", mem_addr, n_iss);
                end
                n_iss++;
            end
            if (stalled) begin
                tests_run++;
                if (w_valid !== 1'b1 || w_data !== held) begin
                    tests_failed++;
                    $display("FAIL bp_stall_hold: got valid=%b data=%h required 1 %h",
                             w_valid, w_data, held);
                end
            end
            stalled = 1'b0;
            if (w_valid) begin
                if (w_ready) begin
                    got = {w_data, w_last_neuron, w_last, neuron_idx};
                    exp = {8'(n_hs % 256), (n_hs % 169) == 168, n_hs == 506, 2'(n_hs / 169)};
                    tests_run++;
                    if (got !== exp) begin
                        tests_failed++;
                        $display("FAIL bp_beat%0d: got %h required %h", n_hs, got, exp);
                    end
                    n_hs++;
                end else begin
                    held    = w_data;
                    stalled = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (done !== 1'b1 || n_hs != 507 || n_iss != 507) begin
            tests_failed++;
            $display("FAIL bp_complete: got done=%b beats=%0d reads=%0d required 1 507 507",
                     done, n_hs, n_iss);
        end
        w_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stream();
        int          n_hs = 0;
        int          cyc  = 0;
        logic [24:0] got;
        w_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (n_hs < 100 && cyc < 300) begin
            if (w_valid && w_ready) n_hs++;
            @(negedge clk);
            cyc++;
        end
        #2 rst = 1'b1;
        #1;
        got = {busy, done, mem_en, w_valid, w_last_neuron, w_last, mem_addr, w_data, neuron_idx};
        tests_run++;
        if (n_hs != 100 || got !== 25'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got beats=%0d outs=%h required 100 0", n_hs, got);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if ({mem_en, mem_addr, w_valid} !== {1'b1, 10'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL rst_restart_addr: got en=%b addr=%0d valid=%b required 1 0 0",
                     mem_en, mem_addr, w_valid);
        end
        @(negedge clk);
        tests_run++;
        if (w_valid !== 1'b0 || w_data !== 8'd0) begin
            tests_failed++;
            $display("FAIL rst_no_stale: got valid=%b data=%h required 0 0", w_valid, w_data);
        end
        @(negedge clk);
        tests_run++;
        if ({w_valid, w_data, neuron_idx} !== {1'b1, 8'd0, 2'd0}) begin
            tests_failed++;
            $display("FAIL rst_first_beat: got valid=%b data=%h idx=%0d required 1 0 0",
                     w_valid, w_data, neuron_idx);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 700) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_stream_done: got %b required 1", done);
        end
        @(negedge clk);
    endtask

`ifdef DENSE_WS_CHECKSUM_EN
    task automatic test_checksum();
        int cyc = 0;
        rom_ff  = 1'b1;
        w_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && cyc < 700) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (done !== 1'b1 || checksum !== 24'hFFFE05) begin
            tests_failed++;
            $display("FAIL checksum_done: got done=%b sum=%h required 1 fffe05", done, checksum);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (checksum !== 24'hFFFE05) begin
            tests_failed++;
            $display("FAIL checksum_hold: got %h required fffe05", checksum);
        end
        rom_ff = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_full_stream();
        test_back_to_back();
        test_reset_mid_stream();
`ifdef DENSE_WS_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
